// File: rtl/wave_ram_arbiter.sv
// Round-robin arbiter that funnels NUM_CH wave-capture write requests into
// one banked sample-RAM write port. Each channel owns a single-entry holding
// register. One pending entry is drained per cycle, and the channel index is
// used as the bank select.

// Per-channel holding register: accepts a sample when empty, or when it is
// being drained this cycle. Otherwise it flags a drop and keeps the held entry.
module wave_ram_slot #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              grant,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              pend,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              ack,
  output logic              drop
);

  logic accept;

  assign accept = req & (~pend | grant);
  assign drop   = req & pend & ~grant;

  // Capture on accept. A refill during the grant cycle keeps pend set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
      addr <= '0;
      data <= '0;
      ack  <= 1'b0;
    end else begin
      ack <= accept;
      if (accept) begin
        pend <= 1'b1;
        addr <= req_addr;
        data <= req_data;
      end else if (grant) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

module wave_ram_arbiter #(
  parameter int NUM_CH  = 11,
  parameter int CH_BITS = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        ack,
  output logic                     ram_we,
  output logic [CH_BITS-1:0]       ram_ch,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  output logic [NUM_CH-1:0]        overflow,
  input  logic                     clear_overflow,
  output logic                     busy
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  logic [NUM_CH-1:0]              pend;
  logic [NUM_CH-1:0]              drop;
  logic [NUM_CH-1:0]              grant;
  logic [NUM_CH-1:0][ADDR_W-1:0]  held_addr;
  logic [NUM_CH-1:0][DATA_W-1:0]  held_data;
  logic [CH_BITS-1:0]             rr_ptr;
  logic [CH_BITS-1:0]             gnt_idx;
  logic                           gnt_vld;
  logic [CH_BITS:0]               scan;
  wr_ent_t                        sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    wave_ram_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .req      (req[i]),
      .grant    (grant[i]),
      .req_addr (req_addr[i*ADDR_W +: ADDR_W]),
      .req_data (req_data[i*DATA_W +: DATA_W]),
      .pend     (pend[i]),
      .addr     (held_addr[i]),
      .data     (held_data[i]),
      .ack      (ack[i]),
      .drop     (drop[i])
    );
    assign grant[i] = gnt_vld && (gnt_idx == CH_BITS'(i));
  end

  // Scan upward from rr_ptr with wrap at NUM_CH. The first pending channel wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan = {1'b0, rr_ptr} + (CH_BITS+1)'(k);
      if (scan >= (CH_BITS+1)'(NUM_CH))
        scan = scan - (CH_BITS+1)'(NUM_CH);
      if (!gnt_vld && pend[scan[CH_BITS-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[CH_BITS-1:0];
      end
    end
  end

  // Select the held entry of the granted channel. grant is one-hot or zero.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) sel = '{addr: held_addr[i], data: held_data[i]};
  end

  // RAM port registers and pointer advance. The port holds its last values when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_we   <= 1'b0;
      ram_ch   <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      rr_ptr   <= '0;
    end else begin
      ram_we <= gnt_vld;
      if (gnt_vld) begin
        ram_ch   <= gnt_idx;
        ram_addr <= sel.addr;
        ram_din  <= sel.data;
        rr_ptr   <= (gnt_idx == CH_BITS'(NUM_CH-1)) ? '0 : gnt_idx + CH_BITS'(1);
      end
    end
  end

  // Sticky drop flags. A drop in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= '0;
    else        overflow <= (clear_overflow ? '0 : overflow) | drop;
  end

  assign busy = |pend;

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Directed bench for wave_ram_arbiter. A channel-level model predicts the
// outputs of every cycle. Literal checks in the stimulus pin the model.
module tb_wave_ram_arbiter;

  localparam int NC = 11;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NC-1:0]    req = '0;
  logic [NC*9-1:0]  req_addr = '0;
  logic [NC*8-1:0]  req_data = '0;
  logic             clear_overflow = 1'b0;
  logic [NC-1:0]    ack;
  logic             ram_we;
  logic [3:0]       ram_ch;
  logic [8:0]       ram_addr;
  logic [7:0]       ram_din;
  logic [NC-1:0]    overflow;
  logic             busy;

  int total = 0;
  int bad   = 0;

  wave_ram_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .ack            (ack),
    .ram_we         (ram_we),
    .ram_ch         (ram_ch),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel-level model: each channel holds 0 or 1 sample. One per cycle goes
  // to RAM, chosen by rotating priority starting after the last served channel.
  bit          m_pend [NC];
  logic [8:0]  m_addr [NC];
  logic [7:0]  m_data [NC];
  int          m_rr = 0;
  logic [NC-1:0] m_ov = '0, e_ack = '0;
  logic        e_we = 1'b0;
  logic [3:0]  e_ch = '0;
  logic [8:0]  e_addr = '0;
  logic [7:0]  e_din = '0;

  always @(posedge clk) begin : model
    int g;
    bit any;
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin m_pend[i] = 0; m_addr[i] = '0; m_data[i] = '0; end
      m_rr = 0; m_ov = '0; e_ack = '0; e_we = 0; e_ch = '0; e_addr = '0; e_din = '0;
    end else begin
      g = -1;
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (m_rr + k) % NC;
        if (g < 0 && m_pend[c]) g = c;
      end
      e_ack = '0;
      if (g >= 0) begin
        e_we = 1; e_ch = 4'(g); e_addr = m_addr[g]; e_din = m_data[g];
        m_pend[g] = 0; m_rr = (g + 1) % NC;
      end else e_we = 0;
      if (clear_overflow) m_ov = '0;
      for (int i = 0; i < NC; i++)
        if (req[i]) begin
          if (!m_pend[i]) begin
            m_pend[i] = 1; m_addr[i] = req_addr[i*9 +: 9]; m_data[i] = req_data[i*8 +: 8];
            e_ack[i] = 1'b1;
          end else m_ov[i] = 1'b1;
        end
    end
    #1;
    any = 0;
    for (int i = 0; i < NC; i++) any |= m_pend[i];
    chk("m_we", 32'(ram_we), 32'(e_we));
    chk("m_ch", 32'(ram_ch), 32'(e_ch));
    chk("m_addr", 32'(ram_addr), 32'(e_addr));
    chk("m_din", 32'(ram_din), 32'(e_din));
    chk("m_ack", 32'(ack), 32'(e_ack));
    chk("m_ovf", 32'(overflow), 32'(m_ov));
    chk("m_busy", 32'(busy), 32'(any));
  end

  task automatic put(input int ch, input logic [8:0] a, input logic [7:0] d);
    req[ch] = 1'b1;
    req_addr[ch*9 +: 9] = a;
    req_data[ch*8 +: 8] = d;
  endtask

  task automatic put_all();
    for (int i = 0; i < NC; i++) put(i, 9'(i * 3), 8'(i));
  endtask

  initial begin
    int seen7;
    // reset held, then idle
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ch", 32'(ram_ch), 0);
    chk("idle_ack", 32'(ack), 0);

    // fairness from rr_ptr=0
    put_all();
    @(negedge clk); req = '0;
    chk("rr0_ack", 32'(ack), 32'h7FF);
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      chk("rr0_we", 32'(ram_we), 1);
      chk("rr0_ch", 32'(ram_ch), 32'(k));
      chk("rr0_din", 32'(ram_din), 32'(k));
    end
    @(negedge clk);
    chk("rr0_idle", 32'(ram_we), 0);

    // single channel
    put(3, 9'h05A, 8'hC3);
    @(negedge clk); req = '0;
    chk("one_ack", 32'(ack), 32'h008);
    @(negedge clk);
    chk("one_we", 32'(ram_we), 1);
    chk("one_ch", 32'(ram_ch), 3);
    chk("one_addr", 32'(ram_addr), 32'h05A);
    chk("one_din", 32'(ram_din), 32'hC3);
    chk("one_busy", 32'(busy), 0);
    @(negedge clk);
    chk("one_done", 32'(ram_we), 0);

    // fairness from rr_ptr=4
    put_all();
    @(negedge clk); req = '0;
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      chk("rr4_ch", 32'(ram_ch), 32'((4 + k) % NC));
      chk("rr4_din", 32'(ram_din), 32'((4 + k) % NC));
    end
    @(negedge clk);

    // overflow on channel 7 while 0-6 are pending
    for (int i = 0; i < 7; i++) put(i, 9'(i), 8'(8'h30 + i));
    @(negedge clk); req = '0; put(7, 9'h077, 8'h71);
    @(negedge clk); req = '0; put(7, 9'h078, 8'h72);
    @(negedge clk); req = '0;
    chk("ovf_set", 32'(overflow), 32'h080);
    chk("ovf_noack", 32'(ack), 0);
    seen7 = 0;
    repeat (10) begin
      @(negedge clk);
      if (ram_we && ram_ch == 4'd7) begin
        seen7++;
        chk("ovf_keep", 32'(ram_din), 32'h71);
      end
    end
    chk("ovf_seen7", 32'(seen7), 1);
    clear_overflow = 1'b1;
    @(negedge clk); clear_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // clear concurrent with a channel-2 drop
    put(1, 9'h001, 8'h01); put(2, 9'h002, 8'h02); put(9, 9'h009, 8'h09);
    @(negedge clk); req = '0; put(1, 9'h101, 8'hE1);
    @(negedge clk); req = '0;
    chk("ovf_pre", 32'(overflow), 32'h002);
    put(2, 9'h102, 8'hE2); clear_overflow = 1'b1;
    @(negedge clk); req = '0; clear_overflow = 1'b0;
    chk("ovf_race", 32'(overflow), 32'h004);
    repeat (3) @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk); clear_overflow = 1'b0;

    // drain-and-refill on channel 5
    put(5, 9'h055, 8'hAA);
    @(negedge clk); req = '0; put(5, 9'h056, 8'h11);
    chk("rf_ack0", 32'(ack), 32'h020);
    @(negedge clk); req = '0;
    chk("rf_we", 32'(ram_we), 1);
    chk("rf_ch", 32'(ram_ch), 5);
    chk("rf_old", 32'(ram_din), 32'hAA);
    chk("rf_ack", 32'(ack), 32'h020);
    chk("rf_ovf", 32'(overflow), 0);
    chk("rf_busy", 32'(busy), 1);
    @(negedge clk);
    chk("rf_new", 32'(ram_din), 32'h11);
    chk("rf_addr", 32'(ram_addr), 32'h056);
    chk("rf_idle", 32'(busy), 0);
    @(negedge clk);

    // async reset mid-burst
    for (int i = 0; i < NC; i += 2) put(i, 9'(i), 8'(8'h50 + i));
    @(negedge clk); req = '0;
    @(negedge clk);
    chk("ar_we_pre", 32'(ram_we), 1);
    chk("ar_busy_pre", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_we", 32'(ram_we), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ack", 32'(ack), 0);
    chk("ar_ch", 32'(ram_ch), 0);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); put(9, 9'h1FF, 8'h99);
    @(negedge clk); req = '0;
    chk("ar_ack9", 32'(ack), 32'h200);
    @(negedge clk);
    chk("ar_we9", 32'(ram_we), 1);
    chk("ar_ch9", 32'(ram_ch), 9);
    chk("ar_din9", 32'(ram_din), 32'h99);
    @(negedge clk);
    chk("ar_end", 32'(ram_we), 0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_ram_arbiter.md
Name: wave_ram_arbiter

Overview:
Shares one write port of a banked waveform sample RAM among NUM_CH wave-capture requesters: the composite-mix capture plus the per-note captures.
Each requester gets a single-entry holding register. A round-robin scheduler drains one pending entry per cycle into the shared RAM port, with the channel index as bank select.
Sits between the wave_capture instances and the sample RAM in the wave display top level. This removes the need for one RAM per channel with a shared write enable.

Parameters:
NUM_CH, 11, number of requesting capture channels
CH_BITS, 4, width of channel index (ceil(log2(NUM_CH)))
ADDR_W, 9, per-channel sample address width
DATA_W, 8, sample width

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_CH  per-channel write request, one-cycle pulse per sample
req_addr  input  NUM_CH*ADDR_W  flattened addresses; channel i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_CH*DATA_W  flattened samples; channel i at [i*DATA_W +: DATA_W]
ack  output  NUM_CH  registered; bit i high one cycle after channel i's request is accepted
ram_we  output  1  shared RAM write enable
ram_ch  output  CH_BITS  bank select (channel index) for the current write
ram_addr  output  ADDR_W  address within the bank
ram_din  output  DATA_W  write data
overflow  output  NUM_CH  sticky; bit i set when a channel i request is dropped
clear_overflow  input  1  single-cycle clear of all overflow bits
busy  output  1  high while any holding register is occupied

Behaviour:
- Reset (reset==0, asynchronous): pend, ack, overflow, ram_we = 0. ram_ch, ram_addr, ram_din = 0. rr_ptr = 0.
- Holding register i: fields pend[i], addr, data.
  - req[i] is accepted when pend[i]==0, or when channel i is granted in the same cycle (drain-and-refill).
  - On accept: addr/data are captured and pend[i] is set at the next edge; ack[i] is high for that cycle.
- Drop rule: req[i] while pend[i]==1 and channel i is not granted this cycle.
  - The new sample is dropped; the held entry is unchanged.
  - overflow[i] is set at the next edge; no ack.
- Grant, combinational each cycle: the lowest-index pending channel searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_CH-1, 0, ...). At most one grant per cycle.
- On grant of channel g, at the next edge:
  - ram_we=1, ram_ch=g, ram_addr/ram_din take the held values.
  - pend[g] clears unless it is refilled in the same cycle.
  - rr_ptr = (g+1) mod NUM_CH; it wraps at NUM_CH-1 to 0, not at 2^CH_BITS.
- No pending channel: ram_we=0; ram_ch/addr/din hold their last values; rr_ptr unchanged.
- Latency: req at edge t, pend at t+1, earliest ram_we at t+2.
  - Worst-case wait for a pending entry is NUM_CH cycles.
  - A channel requesting at most once per NUM_CH+1 cycles never overflows.
- Simultaneous events:
  - clear_overflow with a new drop in the same cycle: the new drop's bit ends set; all other bits clear.
  - Refill of granted channel g: the old entry is written to RAM, the new entry is held, ack[g]=1, no overflow.
- busy = |pend (combinational from registers).
- Reset mid-operation: pending entries are discarded, no partial write is issued, and ram_we drops immediately. After release, the first grant starts from channel 0.
- Widths: all outputs are zero-extended registers; channel index comparisons use CH_BITS bits.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no req -> ram_we=0, ack=0, overflow=0, busy=0, ram_ch=0 on every cycle.
- Single channel: req[3]=1 with addr=9'h05A, data=8'hC3 at cycle 0 -> ack[3]=1 at cycle 1; ram_we=1, ram_ch=3, ram_addr=5A, ram_din=C3 at cycle 2; busy back to 0 at cycle 2.
- Round-robin fairness: all 11 req in one cycle, data=channel index -> ram_ch sequence 0,1,...,10 on 11 consecutive cycles, ram_din matching.
  - Then repeat with rr_ptr=4 (last grant 3) -> order 4..10,0..3.
- Overflow: req[7] on two consecutive cycles while channels 0-6 are pending -> first sample acked and written; second dropped, no ack; overflow[7]=1.
  - clear_overflow pulse -> overflow=0.
  - clear_overflow concurrent with a new channel-2 drop -> overflow=0x004.
- Drain-and-refill: channel 5 the only pending entry, req[5] in its grant cycle with data=8'h11 -> old data written, ack[5]=1, 8'h11 written next cycle, overflow[5]=0.
- Async reset mid-burst: assert reset between clock edges with 6 channels pending -> ram_we, pend, busy drop to 0 without a clock edge. After release, the next req[9] is written as the first grant with ram_ch=9.
